// File: rtl/uart_pkg.sv
// Shared UART typedefs: frame options and the transmit-arbiter state machine encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } uart_parity_e;

  typedef enum logic {
    STOP_1,
    STOP_2
  } uart_stop_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    HOLD
  } tx_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             found
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte streams onto one UART transmitter, round-robin per packet,
// with a cap of MAX_BURST bytes per grant before the next requester gets a turn.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DBIT      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*DBIT-1:0] i_req_data,
  input  logic [N_REQ-1:0]      i_req_last,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_grant,
  output logic                  o_tx_en,
  output logic [DBIT-1:0]       o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  tx_arb_state_e  state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  g_q, g_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;

  logic [N_REQ-1:0] pick_gnt;
  logic             pick_found;
  logic             tx_en;
  logic [N_REQ-1:0] ready;
  logic [DBIT-1:0]  req_data_a [N_REQ];

  function automatic logic [PW-1:0] oh2idx(input logic [N_REQ-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = PW'(i);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(N_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  // The counter stops at the cap, so it can never roll over to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CW'(MAX_BURST)) return c;
    return c + 1'b1;
  endfunction

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_data_a[k] = i_req_data[k*DBIT +: DBIT];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tx_en   = 1'b0;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          g_d     = oh2idx(pick_gnt);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_en     = 1'b1;
        ready[g_q] = 1'b1;
        cnt_d     = sat_inc(cnt_q);
        last_d    = i_req_last[g_q];
        state_d   = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          if (last_q || (cnt_q == CW'(MAX_BURST))) begin
            ptr_d   = wrap_inc(g_q);
            state_d = IDLE;
          end else if (i_req_valid[g_q]) begin
            state_d = SEND;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_req_valid[g_q]) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, whatever state the register holds.
  assign o_tx_en     = tx_en & ~i_rst;
  assign o_req_ready = ready & {N_REQ{~i_rst}};
  assign o_grant     = (state_q != IDLE && !i_rst) ? (N_REQ'(1) << g_q) : '0;
  assign o_busy      = (state_q != IDLE) & ~i_rst;
  assign o_tx_data   = req_data_a[g_q];

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL take parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 The module SHALL take parameter DBIT, default 8: data bits per UART frame.
REQ-003 The module SHALL take parameter MAX_BURST, default 16: maximum bytes per grant before forced rearbitration, 1..255.
REQ-004 i_clk  in  1  single clock; reset is synchronous and active-high.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_req_valid  in  N_REQ  per-requester byte valid.
REQ-007 i_req_data  in  N_REQ*DBIT  per-requester byte; requester k occupies bits [k*DBIT +: DBIT].
REQ-008 i_req_last  in  N_REQ  per-requester marker: this byte ends the packet.
REQ-009 o_req_ready  out  N_REQ  one-hot byte-accept strobe.
REQ-010 o_grant  out  N_REQ  one-hot current owner; all zero when no owner.
REQ-011 o_tx_en  out  1  one-cycle launch strobe to the transmitter.
REQ-012 o_tx_data  out  DBIT  byte to the transmitter, valid while o_tx_en=1.
REQ-013 i_tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
REQ-014 o_busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SEND, WAIT, HOLD.
REQ-016 IDLE: if any i_req_valid bit is set, the FSM SHALL pick owner g round-robin, searching from index ptr upward with wrap; it SHALL register g, clear the burst counter to 0 and go to SEND; otherwise it SHALL stay in IDLE.
REQ-017 SEND (exactly one cycle): the block SHALL drive o_tx_en=1, o_tx_data=i_req_data[g] and o_req_ready[g]=1, increment the burst counter, register i_req_last[g] and go to WAIT.
REQ-018 The byte SHALL count as transferred only in the SEND cycle; o_req_ready SHALL be 0 in every other state.
REQ-019 Latency: valid seen in IDLE at cycle t SHALL give o_tx_en=1 at cycle t+1.
REQ-020 WAIT: without i_tx_done the FSM SHALL stay in WAIT; i_tx_done in any other state SHALL be ignored.
REQ-021 WAIT with i_tx_done, when the registered last=1 or the burst counter equals MAX_BURST: the FSM SHALL set ptr=(g+1) mod N_REQ, drop the grant and go to IDLE.
REQ-022 WAIT with i_tx_done, when neither condition of REQ-021 holds: the FSM SHALL go to SEND if i_req_valid[g]=1, otherwise to HOLD.
REQ-023 HOLD: the FSM SHALL keep the grant and go to SEND when i_req_valid[g]=1; valid on any other requester SHALL be ignored.
REQ-024 o_grant SHALL be one-hot at g in SEND, WAIT and HOLD, and zero in IDLE.
REQ-025 The burst counter SHALL be ceil(log2(MAX_BURST+1)) bits wide and SHALL never wrap.
REQ-026 Simultaneous valid on several requesters SHALL grant only the first one found from ptr; the others see no ready.
REQ-027 A byte with last=1 and the burst cap reached at the same time SHALL release the grant once, with a single ptr advance.
REQ-028 After release, the next grant SHALL begin no earlier than one IDLE cycle after the release.

Reset
REQ-029 On i_rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, g=0, burst counter=0 and registered last=0; this holds in any state, including mid-frame.
REQ-030 During reset and in the cycle after it, o_tx_en, o_req_ready, o_grant and o_busy SHALL all be 0.

Structure
REQ-031 The state enum SHALL live in the shared package uart_pkg, next to the other UART typedefs.
REQ-032 The round-robin pick SHALL be one combinational sub-module, rr_pick: inputs request vector and ptr; outputs a one-hot grant and a found flag.

Verification
REQ-033 Reset then valid[2]=1 with data 0xA5, last=1, and a done pulse after 10 cycles -> tx_en with 0xA5 one cycle later, ready[2] pulse, grant released on done, ptr=3.
REQ-034 All four valid at once with last=1 each, starting from ptr=0 -> launch order 0,1,2,3, then 0 again.
REQ-035 Requester 1 sends a 3-byte packet while requester 0 stays valid -> bytes 1a,1b,1c go back-to-back with no grant change; requester 0 is served next.
REQ-036 MAX_BURST=4, requester 3 streams 10 bytes with last=0 -> release after 4 bytes; if another requester is valid, its byte goes next.
REQ-037 Requester 0 drops valid after byte 1 of an unfinished packet -> HOLD; valid on requester 1 is ignored; requester 0 returns -> SEND with grant still 0.
REQ-038 i_rst asserted during WAIT, then a stale i_tx_done -> state IDLE, done ignored, no tx_en, ptr=0.
